// File: rtl/axi_ram_pkg.sv
// Shared types for the AXI4 RAM write front-end: burst/response encodings,
// engine state and the queue entry layouts.
package axi_ram_pkg;

  localparam int ID_W_MAX   = 32;
  localparam int ADDR_W_MAX = 64;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    ST_IDLE,
    ST_BURST
  } engState_e;

  // Fields are sized for the widest supported bus; the top slices them down.
  typedef struct packed {
    logic [ID_W_MAX-1:0]   id;
    logic [ADDR_W_MAX-1:0] addr;
    logic [7:0]            len;
    logic [2:0]            size;
    logic [1:0]            burst;
  } awEntry_t;

  typedef struct packed {
    logic [ID_W_MAX-1:0] id;
    logic [1:0]          resp;
  } bEntry_t;

  function automatic logic isWrapLen(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi_ram_sync_fifo.sv
// Small synchronous FIFO with occupancy count; push is honoured when full
// only if a pop happens in the same cycle.
module axi_ram_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wrPtr_q, rdPtr_q;
  logic [CNT_W-1:0] count_q;
  logic             doPush, doPop;

  always_comb begin
    doPop  = pop_i && (count_q != '0);
    doPush = push_i && ((count_q != CNT_W'(DEPTH)) || doPop);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + PTR_W'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(doPush) - CNT_W'(doPop);
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= data_i;
  end

  assign data_o  = mem_q[rdPtr_q];
  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;

endmodule

// File: rtl/axi_ram_wr_if_q.sv
// AXI4 write front-end: queues AW, walks each burst beat by beat into RAM
// write commands and queues B responses. Optional AXI_RAM_WR_RANGE_CHECK_EN.
module axi_ram_wr_if_q
  import axi_ram_pkg::*;
#(
  parameter int              DATA_WIDTH = 32,
  parameter int              ADDR_WIDTH = 16,
  parameter int              STRB_WIDTH = DATA_WIDTH / 8,
  parameter int              ID_WIDTH   = 8,
  parameter int              AW_DEPTH   = 4,
  parameter int              B_DEPTH    = 4,
  parameter longint unsigned MEM_BYTES  = 64'd1 << ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ID_WIDTH-1:0]   s_axi_awid,
  input  logic [ADDR_WIDTH-1:0] s_axi_awaddr,
  input  logic [7:0]            s_axi_awlen,
  input  logic [2:0]            s_axi_awsize,
  input  logic [1:0]            s_axi_awburst,
  input  logic                  s_axi_awvalid,
  output logic                  s_axi_awready,
  input  logic [DATA_WIDTH-1:0] s_axi_wdata,
  input  logic [STRB_WIDTH-1:0] s_axi_wstrb,
  input  logic                  s_axi_wlast,
  input  logic                  s_axi_wvalid,
  output logic                  s_axi_wready,
  output logic [ID_WIDTH-1:0]   s_axi_bid,
  output logic [1:0]            s_axi_bresp,
  output logic                  s_axi_bvalid,
  input  logic                  s_axi_bready,
  output logic [ID_WIDTH-1:0]   ram_wr_cmd_id,
  output logic [ADDR_WIDTH-1:0] ram_wr_cmd_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_cmd_data,
  output logic [STRB_WIDTH-1:0] ram_wr_cmd_strb,
  output logic                  ram_wr_cmd_en,
  output logic                  ram_wr_cmd_last,
  input  logic                  ram_wr_cmd_ready
);

  localparam int SIZE_MAX = $clog2(STRB_WIDTH);
  localparam int AWC_W    = $clog2(AW_DEPTH) + 1;
  localparam int BC_W     = $clog2(B_DEPTH) + 1;

  awEntry_t            awIn, awHead;
  bEntry_t             bIn, bHead;
  logic                awPush, awPop, awFull, awEmpty;
  logic                bPush, bPop, bFull, bEmpty;
  logic [AWC_W-1:0]    awCount, awCountNext;
  logic [BC_W-1:0]     bCount;
  logic                awReady_q, awReady_d;

  engState_e           state_q;
  logic [ID_WIDTH-1:0]   id_q;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            count_q, len_q;
  logic [2:0]            size_q;
  logic [1:0]            burst_q;
  logic                  err_q;

  logic                  inBurst, beatFire, lastBeat, canLoad, beatErr;
  logic [ADDR_WIDTH-1:0] beatBytes, wrapMask;
  logic [2:0]            awSizeClamped;
  logic [1:0]            awBurstEff;

  // Size is clamped to the bus width and unsupported WRAP lengths degrade to INCR
  // at enqueue time, so the engine only ever sees legal burst descriptions.
  always_comb begin
    awSizeClamped = (s_axi_awsize > 3'(SIZE_MAX)) ? 3'(SIZE_MAX) : s_axi_awsize;
    awBurstEff    = s_axi_awburst;
    if (s_axi_awburst == BURST_WRAP && !isWrapLen(s_axi_awlen)) awBurstEff = BURST_INCR;
    awIn.id    = ID_W_MAX'(s_axi_awid);
    awIn.addr  = ADDR_W_MAX'(s_axi_awaddr);
    awIn.len   = s_axi_awlen;
    awIn.size  = awSizeClamped;
    awIn.burst = awBurstEff;
    awPush     = s_axi_awvalid && awReady_q && !awFull;
  end

  always_comb begin
    inBurst   = (state_q == ST_BURST);
    beatFire  = inBurst && s_axi_wvalid && ram_wr_cmd_ready;
    lastBeat  = (count_q == 8'd0);
    canLoad   = !awEmpty && ((int'(bCount) + int'(inBurst)) < B_DEPTH);
    awPop     = canLoad && (!inBurst || (beatFire && lastBeat));
    beatBytes = ADDR_WIDTH'(1) << size_q;
    wrapMask  = ((ADDR_WIDTH'(len_q) + ADDR_WIDTH'(1)) << size_q) - ADDR_WIDTH'(1);
    case (burst_q)
      BURST_FIXED: addr_d = addr_q;
      BURST_WRAP:  addr_d = (addr_q & ~wrapMask) | ((addr_q + beatBytes) & wrapMask);
      default:     addr_d = addr_q + beatBytes;
    endcase
`ifdef AXI_RAM_WR_RANGE_CHECK_EN
    beatErr = (64'(addr_q) + 64'(beatBytes)) > 64'(MEM_BYTES);
`else
    beatErr = 1'b0;
`endif
    awCountNext = awCount + AWC_W'(awPush) - AWC_W'(awPop);
    awReady_d   = (awCountNext != AWC_W'(AW_DEPTH));
    bPush       = beatFire && lastBeat;
    bPop        = !bEmpty && s_axi_bready;
    bIn.id      = ID_W_MAX'(id_q);
    bIn.resp    = (err_q || beatErr) ? RESP_SLVERR : RESP_OKAY;
  end

  // A burst's last beat may hand over straight to the next queued AW.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      count_q   <= '0;
      len_q     <= '0;
      size_q    <= '0;
      burst_q   <= '0;
      err_q     <= 1'b0;
      awReady_q <= 1'b0;
    end else begin
      awReady_q <= awReady_d;
      if (awPop) begin
        state_q <= ST_BURST;
        id_q    <= awHead.id[ID_WIDTH-1:0];
        addr_q  <= awHead.addr[ADDR_WIDTH-1:0];
        count_q <= awHead.len;
        len_q   <= awHead.len;
        size_q  <= awHead.size;
        burst_q <= awHead.burst;
        err_q   <= 1'b0;
      end else if (beatFire) begin
        if (lastBeat) begin
          state_q <= ST_IDLE;
        end else begin
          count_q <= count_q - 8'd1;
          addr_q  <= addr_d;
          err_q   <= err_q || beatErr;
        end
      end
    end
  end

  axi_ram_sync_fifo #(.WIDTH($bits(awEntry_t)), .DEPTH(AW_DEPTH)) awFifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (awPush),
    .data_i  (awIn),
    .pop_i   (awPop),
    .data_o  (awHead),
    .full_o  (awFull),
    .empty_o (awEmpty),
    .count_o (awCount)
  );

  axi_ram_sync_fifo #(.WIDTH($bits(bEntry_t)), .DEPTH(B_DEPTH)) bFifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (bPush),
    .data_i  (bIn),
    .pop_i   (bPop),
    .data_o  (bHead),
    .full_o  (bFull),
    .empty_o (bEmpty),
    .count_o (bCount)
  );

  assign s_axi_awready   = awReady_q;
  assign s_axi_wready    = inBurst && ram_wr_cmd_ready;
  assign s_axi_bvalid    = !bEmpty;
  assign s_axi_bid       = bEmpty ? '0 : bHead.id[ID_WIDTH-1:0];
  assign s_axi_bresp     = bEmpty ? RESP_OKAY : bHead.resp;
  assign ram_wr_cmd_id   = id_q;
  assign ram_wr_cmd_addr = addr_q;
  assign ram_wr_cmd_data = s_axi_wdata;
  assign ram_wr_cmd_strb = s_axi_wstrb;
  assign ram_wr_cmd_en   = inBurst && s_axi_wvalid && !beatErr;
  assign ram_wr_cmd_last = inBurst && lastBeat;

endmodule
